// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles every bus-level signal around the data-memory port arbiter:
//     cpu_*  : CPU load/store side (absolute byte addresses)
//     dbg_*  : word-wide debug/DMA requester (level req, one-cycle ack)
//     dm_*   : the single DMEM port (byte offsets, combinational read)
//   Modports:
//     slave  : the arbiter's view (consumes cpu/dbg requests and dm_rdata)
//     master : the environment's view (CPU, debug requester and DMEM)
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    // CPU side
    logic        cpu_r;
    logic        cpu_w;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteena;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_fault;

    // Debug / DMA side
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dbg_err;

    // DMEM side
    logic        dm_r;
    logic        dm_w;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_byteena;
    logic [31:0] dm_rdata;

    modport slave (
        input  cpu_r, cpu_w, cpu_addr, cpu_wdata, cpu_byteena,
        output cpu_rdata, cpu_stall, cpu_fault,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata, dbg_err,
        output dm_r, dm_w, dm_addr, dm_wdata, dm_byteena,
        input  dm_rdata
    );

    modport master (
        output cpu_r, cpu_w, cpu_addr, cpu_wdata, cpu_byteena,
        input  cpu_rdata, cpu_stall, cpu_fault,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata, dbg_err,
        input  dm_r, dm_w, dm_addr, dm_wdata, dm_byteena,
        output dm_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single DMEM port between the CPU load/store path and a
//   word-wide debug/DMA requester. The CPU has priority and sees a purely
//   combinational pass-through (base-address translation + range check).
//   The debug port waits for an idle CPU cycle, or is force-granted after
//   STARVE_MAX busy WAIT cycles, which stalls the CPU for that one cycle.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous, active-low reset
//     bus  : dmem_port_arbiter_if.slave (cpu_*, dbg_*, dm_* signals)
//
//   Parameters:
//     BASE_ADDR   : absolute byte address mapped to DMEM offset 0
//     DEPTH_BYTES : valid offsets are [0, DEPTH_BYTES)
//     STARVE_MAX  : busy WAIT cycles before a forced grant (>= 1)
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned DEPTH_BYTES = 8192,
    parameter int unsigned STARVE_MAX  = 8
) (
    input  logic                clk,
    input  logic                rst,
    dmem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_GRANT = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam int              CNT_W       = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_MAX - 1);
    localparam logic [31:0]     DEPTH       = 32'(DEPTH_BYTES);

    state_t           state_q;
    logic [CNT_W-1:0] starve_q;
    logic             dbg_ack_q;
    logic             dbg_err_q;
    logic [31:0]      dbg_rdata_q;

    logic [31:0] cpu_off;
    logic [31:0] dbg_off;
    logic        cpu_oor;
    logic        dbg_bad;
    logic        cpu_act;
    logic        granted;

    // Modular subtraction: addresses below BASE_ADDR wrap to huge offsets,
    // but the explicit "< BASE_ADDR" term keeps the intent obvious.
    assign cpu_off = bus.cpu_addr - BASE_ADDR;
    assign dbg_off = bus.dbg_addr - BASE_ADDR;
    assign cpu_oor = (bus.cpu_addr < BASE_ADDR) || (cpu_off >= DEPTH);
    assign dbg_bad = (bus.dbg_addr < BASE_ADDR) || (dbg_off >= DEPTH) ||
                     (bus.dbg_addr[1:0] != 2'b00);
    assign cpu_act = bus.cpu_r | bus.cpu_w;
    assign granted = (state_q == S_GRANT);

    // Debug-side FSM; all dbg_* outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= 32'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.dbg_req) begin
                        if (dbg_bad) begin
                            // Rejected without touching DMEM: ack next cycle.
                            state_q     <= S_ACK;
                            dbg_ack_q   <= 1'b1;
                            dbg_err_q   <= 1'b1;
                            dbg_rdata_q <= 32'h0;
                        end else begin
                            state_q  <= S_WAIT;
                            starve_q <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    // starve_q counts busy WAIT cycles already seen; the
                    // STARVE_MAX-th busy cycle forces the grant.
                    if (!cpu_act || (starve_q == STARVE_LAST)) begin
                        state_q <= S_GRANT;
                    end else begin
                        starve_q <= starve_q + CNT_W'(1);
                    end
                end
                S_GRANT: begin
                    if (!bus.dbg_we) begin
                        dbg_rdata_q <= bus.dm_rdata;
                    end
                    dbg_err_q <= 1'b0;
                    dbg_ack_q <= 1'b1;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    // dbg_req is deliberately not looked at here.
                    dbg_ack_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // DMEM port mux. Reset gates the strobes so nothing reaches DMEM while
    // rst is low, even if the CPU keeps strobing.
    always_comb begin
        bus.dm_r       = 1'b0;
        bus.dm_w       = 1'b0;
        bus.dm_addr    = 32'h0;
        bus.dm_wdata   = 32'h0;
        bus.dm_byteena = 4'h0;
        bus.cpu_rdata  = 32'h0;
        bus.cpu_stall  = 1'b0;
        bus.cpu_fault  = 1'b0;
        if (rst) begin
            if (granted) begin
                bus.dm_r       = !bus.dbg_we;
                bus.dm_w       = bus.dbg_we;
                bus.dm_addr    = dbg_off;
                bus.dm_wdata   = bus.dbg_wdata;
                bus.dm_byteena = 4'hF;
                bus.cpu_stall  = cpu_act;
            end else if (cpu_act) begin
                if (cpu_oor) begin
                    bus.cpu_fault = 1'b1;
                end else begin
                    bus.dm_r       = bus.cpu_r;
                    bus.dm_w       = bus.cpu_w;
                    bus.dm_addr    = cpu_off;
                    bus.dm_wdata   = bus.cpu_wdata;
                    bus.dm_byteena = bus.cpu_byteena;
                    bus.cpu_rdata  = bus.dm_rdata;
                end
            end
        end
    end

    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.dbg_err   = dbg_err_q;
    assign bus.dbg_rdata = dbg_rdata_q;

endmodule
